// File: rtl/clock_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clock_gate_ctrl
//
// Produces the enable for the clock gater cell (E pin) of one gated clock
// domain. Runs on the free-running clock. The domain is gated after a
// programmable run of idle cycles, or on an explicit sleep request. It is
// re-enabled on a wake request, and readiness is flagged after a settle delay.
//
// Parameters
//   IDLE_CYCLES  consecutive idle cycles required before gating (>= 1)
//   WAKE_CYCLES  cycles ClkEn is high before ClkRdy asserts   (>= 1)
//
// Ports
//   clk         in   free-running (ungated) clock
//   reset_n     in   asynchronous, active-low reset
//   AutoGateEn  in   1 = automatic idle gating allowed
//   Busy        in   1 = work pending in the gated domain
//   SleepReq    in   level request to gate the domain
//   WakeReq     in   level request to ungate; overrides every sleep cause
//   SleepAck    out  1 = domain gated in response to SleepReq
//   ClkEn       out  to gater E input; 1 = clock runs
//   ClkRdy      out  1 = gated clock running and settled
//   Gated       out  1 = clock currently gated
//
// All outputs are flops loaded from the next-state decode, so there is no
// combinational path from any input to any output.
// ---------------------------------------------------------------------------
module clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic AutoGateEn,
  input  logic Busy,
  input  logic SleepReq,
  input  logic WakeReq,
  output logic SleepAck,
  output logic ClkEn,
  output logic ClkRdy,
  output logic Gated
);

  localparam int MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] S_WAKE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_GATED = 2'd3;

  // Parameter legality is checked at elaboration.
  if (IDLE_CYCLES < 1) begin : g_idle_chk
    $error("clock_gate_ctrl: IDLE_CYCLES must be >= 1");
  end
  if (WAKE_CYCLES < 1) begin : g_wake_chk
    $error("clock_gate_ctrl: WAKE_CYCLES must be >= 1");
  end

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          slp_cond;

  // Any sleep cause is present, nothing is pending, and no wake is requested.
  assign slp_cond = ~Busy & (AutoGateEn | SleepReq) & ~WakeReq;

  // NOTE: every signal assigned here gets a default first so that no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_WAKE: begin
        // Settle delay runs to completion; inputs are not looked at.
        if (cnt == WAKE_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_RUN: begin
        // The idle cycle that triggers the move already counts as one.
        if (slp_cond) begin
          state_nxt = S_COUNT;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_COUNT: begin
        if (!slp_cond) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else if (cnt >= IDLE_LAST) begin
          state_nxt = S_GATED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_GATED: begin
        // Busy cannot wake the domain; only a wake request or the loss of
        // both gate causes does.
        if (WakeReq || (!SleepReq && !AutoGateEn)) begin
          state_nxt = S_WAKE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_WAKE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Reset forces ClkEn high immediately; the gater's own latch hides any
  // partial high phase this creates.
  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others, matching real hardware.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_WAKE;
      cnt      <= '0;
      ClkEn    <= 1'b1;
      ClkRdy   <= 1'b0;
      SleepAck <= 1'b0;
      Gated    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ClkEn    <= (state_nxt != S_GATED);
      ClkRdy   <= (state_nxt == S_RUN) || (state_nxt == S_COUNT);
      Gated    <= (state_nxt == S_GATED);
      SleepAck <= (state_nxt == S_GATED) && SleepReq;
    end
  end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_gate_ctrl
//
// Scoreboard bench for clock_gate_ctrl (IDLE_CYCLES=4, WAKE_CYCLES=2).
// The driver applies inputs, advances the reference model one clock edge and
// queues the expected outputs; a monitor on the falling edge pops each entry
// and compares it with the DUT. The model tracks "gated or not", edges since
// the clock was re-enabled and the length of the current idle streak.
// ---------------------------------------------------------------------------
module tb_clock_gate_ctrl;

  localparam int IDLE = 4;
  localparam int WAKE = 2;
  // The first idle cycle only arms the counter, so at least two idle edges
  // are needed even when IDLE is 1.
  localparam int GATE_AT = (IDLE > 2) ? IDLE : 2;

  typedef struct packed {
    logic clk_en;
    logic clk_rdy;
    logic gated;
    logic sleep_ack;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic auto_gate_en = 1'b0;
  logic busy = 1'b0;
  logic sleep_req = 1'b0;
  logic wake_req = 1'b0;
  logic sleep_ack, clk_en, clk_rdy, gated;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  // Reference model state
  bit m_gated;
  int m_elapsed;
  int m_streak;
  bit m_ack;

  clock_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .AutoGateEn (auto_gate_en),
    .Busy       (busy),
    .SleepReq   (sleep_req),
    .WakeReq    (wake_req),
    .SleepAck   (sleep_ack),
    .ClkEn      (clk_en),
    .ClkRdy     (clk_rdy),
    .Gated      (gated)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_gated   = 1'b0;
    m_elapsed = 0;
    m_streak  = 0;
    m_ack     = 1'b0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.clk_en    = !m_gated;
    e.clk_rdy   = !m_gated && (m_elapsed >= WAKE);
    e.gated     = m_gated;
    e.sleep_ack = m_ack;
    return e;
  endfunction

  // One clock edge of the reference behaviour, using the sampled inputs.
  function automatic void model_edge(input bit age, input bit bsy, input bit sreq, input bit wreq);
    bit ready;
    bit idle;
    ready = !m_gated && (m_elapsed >= WAKE);
    idle  = !bsy && (age || sreq) && !wreq;
    if (m_gated) begin
      if (wreq || (!sreq && !age)) begin
        m_gated   = 1'b0;
        m_elapsed = 0;
      end
    end else if (!ready) begin
      m_elapsed++;
    end else begin
      m_streak = idle ? m_streak + 1 : 0;
      if (m_streak >= GATE_AT) begin
        m_gated  = 1'b1;
        m_streak = 0;
      end
    end
    m_ack = m_gated && sreq;
  endfunction

  // Advance one edge: model sees the inputs present at the edge, then the
  // inputs may be changed safely 2 time units later.
  task automatic tick();
    @(posedge clk);
    model_edge(auto_gate_en, busy, sleep_req, wake_req);
    exp_q.push_back(model_out());
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_in(input bit age, input bit bsy, input bit sreq, input bit wreq);
    auto_gate_en = age;
    busy         = bsy;
    sleep_req    = sreq;
    wake_req     = wreq;
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ClkEn",    clk_en,    e.clk_en);
      check("ClkRdy",   clk_rdy,   e.clk_rdy);
      check("Gated",    gated,     e.gated);
      check("SleepAck", sleep_ack, e.sleep_ack);
    end
  end

  initial begin
    // Reset state, observed while reset is held.
    #7;
    check("reset ClkEn",    clk_en,    1'b1);
    check("reset ClkRdy",   clk_rdy,   1'b0);
    check("reset Gated",    gated,     1'b0);
    check("reset SleepAck", sleep_ack, 1'b0);
    #1;
    reset_n = 1'b1;
    model_reset();

    // 1: reset release, all inputs low.
    set_in(0, 0, 0, 0);
    ticks(6);

    // 2: automatic idle gating, with an interrupting busy pulse.
    set_in(1, 1, 0, 0);
    ticks(3);
    busy = 1'b0; ticks(2);
    busy = 1'b1; ticks(1);
    busy = 1'b0; ticks(6);

    // 3: wake request from gated, held for a long time.
    wake_req = 1'b1; ticks(12);
    wake_req = 1'b0; ticks(6);

    // 4: explicit sleep request, then release.
    set_in(0, 0, 1, 0);
    ticks(8);
    sleep_req = 1'b0; ticks(6);

    // 5: sleep and wake together; wake must win.
    set_in(1, 0, 1, 1);
    ticks(20);

    // 6: asynchronous reset while gated.
    set_in(0, 0, 1, 0);
    ticks(8);
    check("pre-reset Gated", gated, 1'b1);
    #4;  // away from both clock edges
    reset_n = 1'b0;
    #1;
    check("async ClkEn",    clk_en,    1'b1);
    check("async Gated",    gated,     1'b0);
    check("async ClkRdy",   clk_rdy,   1'b0);
    check("async SleepAck", sleep_ack, 1'b0);
    #1;
    reset_n = 1'b1;
    model_reset();
    set_in(0, 0, 0, 0);
    ticks(6);

    // Randomised phase: inputs change rarely so long idle runs occur.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5)  == 0) busy         = ~busy;
      if ($urandom_range(19) == 0) auto_gate_en = ~auto_gate_en;
      if ($urandom_range(14) == 0) sleep_req    = ~sleep_req;
      if ($urandom_range(11) == 0) wake_req     = ~wake_req;
      tick();
    end

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
